// File: rtl/gcd_cp.sv
// gcd_cp: control path for the subtract-and-swap GCD datapath.
//
// A 2-bit Moore FSM advances on the rising clock edge; the datapath beside it acts on the
// falling edge. The datapath's flags are therefore settled again by the next rising edge.
//
// Ports:
//   clk       in   system clock, state advances on the rising edge
//   rst       in   asynchronous active-low reset, forces LOAD
//   I0        in   datapath flag: XR > 0
//   I1        in   datapath flag: XR >= YR
//   D0, D1    out  raw state encoding {D1,D0}
//   Subtract  out  datapath XR <= XR - YR
//   Swap      out  datapath exchanges XR and YR
//   LoadXR    out  load XR from X (qualified by SelectXY)
//   LoadYR    out  load YR from Y (qualified by SelectXY)
//   SelectXY  out  select external X/Y as the load source
module gcd_cp (
  input  logic clk,
  input  logic rst,
  input  logic I0,
  input  logic I1,
  output logic D0,
  output logic D1,
  output logic Subtract,
  output logic Swap,
  output logic LoadXR,
  output logic LoadYR,
  output logic SelectXY
);

  typedef enum logic [1:0] {
    StLoad = 2'b00,
    StSub  = 2'b01,
    StSwap = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // LOAD, SUB and SWAP share one transition rule; XR == 0 wins over the order flag.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad, StSub, StSwap: begin
        if (!I0) begin
          state_d = StDone;
        end else if (I1) begin
          state_d = StSub;
        end else begin
          state_d = StSwap;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
  end

  // Moore decode: strobes depend on the state register only.
  always_comb begin
    SelectXY = 1'b0;
    LoadXR   = 1'b0;
    LoadYR   = 1'b0;
    Subtract = 1'b0;
    Swap     = 1'b0;
    unique case (state_q)
      StLoad: begin
        SelectXY = 1'b1;
        LoadXR   = 1'b1;
        LoadYR   = 1'b1;
      end
      StSub:   Subtract = 1'b1;
      StSwap:  Swap     = 1'b1;
      StDone:  ;
      default: ;
    endcase
  end

  assign D0 = state_q[0];
  assign D1 = state_q[1];

endmodule

// File: tb/tb_gcd_cp.sv
// Directed bench for gcd_cp; includes a small falling-edge GCD datapath model for the
// end-to-end sequence.
module tb_gcd_cp;

  logic clk;
  logic rst;
  logic I0, I1;
  logic D0, D1, Subtract, Swap, LoadXR, LoadYR, SelectXY;

  logic       dp_en;
  logic       drv_i0, drv_i1;
  logic [7:0] xr, yr, x_in, y_in;

  int checks;
  int failures;

  // {D1,D0,SelectXY,LoadXR,LoadYR,Subtract,Swap}
  localparam logic [6:0] ExpLoad = 7'b00_111_00;
  localparam logic [6:0] ExpSub  = 7'b01_000_10;
  localparam logic [6:0] ExpSwap = 7'b10_000_01;
  localparam logic [6:0] ExpDone = 7'b11_000_00;

  logic [6:0] obs;
  assign obs = {D1, D0, SelectXY, LoadXR, LoadYR, Subtract, Swap};

  assign I0 = dp_en ? (xr != 8'd0) : drv_i0;
  assign I1 = dp_en ? (xr >= yr)   : drv_i1;

  gcd_cp dut (
    .clk      (clk),
    .rst      (rst),
    .I0       (I0),
    .I1       (I1),
    .D0       (D0),
    .D1       (D1),
    .Subtract (Subtract),
    .Swap     (Swap),
    .LoadXR   (LoadXR),
    .LoadYR   (LoadYR),
    .SelectXY (SelectXY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: acts on the falling edge using the FSM strobes.
  always @(negedge clk) begin
    if (SelectXY && (LoadXR || LoadYR)) begin
      if (LoadXR) xr <= x_in;
      if (LoadYR) yr <= y_in;
    end else if (Subtract) begin
      xr <= xr - yr;
    end else if (Swap) begin
      xr <= yr;
      yr <= xr;
    end
  end

  // Pulse reset inside the high phase, releasing before the falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    drv_i0 = 1'b1;
    drv_i1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpLoad) begin
      failures++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, ExpLoad);
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (obs !== ExpLoad) begin
      failures++;
      $display("FAIL reset_release_no_edge obs=%b exp=%b", obs, ExpLoad);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSub) begin
      failures++;
      $display("FAIL reset_first_edge obs=%b exp=%b", obs, ExpSub);
    end
  endtask

  task automatic test_gcd_12_8();
    logic [6:0] exp_seq [5];
    exp_seq[0] = ExpSub;
    exp_seq[1] = ExpSwap;
    exp_seq[2] = ExpSub;
    exp_seq[3] = ExpSub;
    exp_seq[4] = ExpDone;
    x_in  = 8'd12;
    y_in  = 8'd8;
    dp_en = 1'b1;
    do_reset();
    #1;
    checks++;
    if (obs !== ExpLoad) begin
      failures++;
      $display("FAIL gcd_load obs=%b exp=%b", obs, ExpLoad);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_seq[i]) begin
        failures++;
        $display("FAIL gcd_step%0d obs=%b exp=%b", i, obs, exp_seq[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpDone) begin
      failures++;
      $display("FAIL gcd_done_hold obs=%b exp=%b", obs, ExpDone);
    end
    checks++;
    if (yr !== 8'd4) begin
      failures++;
      $display("FAIL gcd_result z=%0d exp=4", yr);
    end
    dp_en = 1'b0;
  endtask

  task automatic test_priority();
    drv_i0 = 1'b1;
    drv_i1 = 1'b1;
    do_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSub) begin
      failures++;
      $display("FAIL prio_enter_sub obs=%b exp=%b", obs, ExpSub);
    end
    drv_i0 = 1'b0;
    drv_i1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpDone) begin
      failures++;
      $display("FAIL prio_i0_over_i1 obs=%b exp=%b", obs, ExpDone);
    end
  endtask

  task automatic test_swap_path();
    drv_i0 = 1'b1;
    drv_i1 = 1'b0;
    do_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSwap) begin
      failures++;
      $display("FAIL swap_enter obs=%b exp=%b", obs, ExpSwap);
    end
    drv_i1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSub) begin
      failures++;
      $display("FAIL swap_to_sub obs=%b exp=%b", obs, ExpSub);
    end
  endtask

  task automatic test_done_sticky();
    drv_i0 = 1'b0;
    drv_i1 = 1'b0;
    do_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpDone) begin
      failures++;
      $display("FAIL done_enter_x0 obs=%b exp=%b", obs, ExpDone);
    end
    for (int i = 0; i < 5; i++) begin
      drv_i0 = i[1];
      drv_i1 = i[0];
      @(posedge clk);
      #1;
      checks++;
      if (obs !== ExpDone) begin
        failures++;
        $display("FAIL done_sticky%0d obs=%b exp=%b", i, obs, ExpDone);
      end
    end
  endtask

  task automatic test_async_reset();
    drv_i0 = 1'b1;
    drv_i1 = 1'b0;
    do_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSwap) begin
      failures++;
      $display("FAIL async_pre_swap obs=%b exp=%b", obs, ExpSwap);
    end
    // No clock edge between here and the check.
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== ExpLoad) begin
      failures++;
      $display("FAIL async_reset_immediate obs=%b exp=%b", obs, ExpLoad);
    end
    #1 rst = 1'b1;
    drv_i1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== ExpSub) begin
      failures++;
      $display("FAIL async_restart obs=%b exp=%b", obs, ExpSub);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    dp_en    = 1'b0;
    drv_i0   = 1'b0;
    drv_i1   = 1'b0;
    x_in     = 8'd0;
    y_in     = 8'd0;
    xr       = 8'd0;
    yr       = 8'd0;
    rst      = 1'b0;
    test_reset();
    test_gcd_12_8();
    test_priority();
    test_swap_path();
    test_done_sticky();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_cp.md
Name: gcd_cp

Overview:
- Control path (FSM) for the subtract-and-swap GCD datapath.
- Samples two status flags from the datapath and decodes the current state into the datapath control strobes: load, subtract, swap.
- Exposes the raw 2-bit state encoding for observation.
- Sits beside the datapath: the datapath acts on the falling clock edge, this FSM advances on the rising edge.

Parameters:
- None.

Ports:
- clk  input  1  system clock; state advances on the rising edge.
- rst  input  1  asynchronous, active-low reset; low forces state LOAD immediately.
- I0  input  1  nonzero flag from datapath: 1 when XR > 0.
- I1  input  1  order flag from datapath: 1 when XR >= YR.
- D0  output  1  state bit 0.
- D1  output  1  state bit 1.
- Subtract  output  1  datapath performs XR <= XR - YR.
- Swap  output  1  datapath exchanges XR and YR.
- LoadXR  output  1  load XR from external input X (qualified by SelectXY).
- LoadYR  output  1  load YR from external input Y (qualified by SelectXY).
- SelectXY  output  1  select external X/Y as the load source.

Behaviour:
- States, encoded {D1,D0}: LOAD=00, SUB=01, SWAP=10, DONE=11.
- Single 2-bit state register, updated on posedge clk.
- rst low asynchronously forces LOAD, independent of clk. While rst is low the state stays LOAD.
- Outputs are Moore: a pure combinational decode of the state register, with no dependence on I0/I1.
  - LOAD: SelectXY=1, LoadXR=1, LoadYR=1, Subtract=0, Swap=0.
  - SUB: Subtract=1; all other strobes 0.
  - SWAP: Swap=1; all other strobes 0.
  - DONE: all strobes 0.
- Exactly one datapath operation is active per state. Subtract and Swap are never both 1.
- D1/D0 always equal the state register.
- Reset output values: state LOAD, so D1=0, D0=0, SelectXY=1, LoadXR=1, LoadYR=1, Subtract=0, Swap=0.
- Next-state rule, identical from LOAD, SUB and SWAP, with flags sampled at the rising edge:
  - I0=0 -> DONE (XR reached 0; the result is in YR).
  - I0=1, I1=1 -> SUB.
  - I0=1, I1=0 -> SWAP.
  - I0 has priority over I1.
- DONE is absorbing: it is left only via reset, regardless of flags.
- Timing contract:
  - The datapath executes the decoded operation on the falling edge inside the state.
  - The flags therefore reflect the updated registers by the next rising edge.
  - One operation per clock; no extra latency or handshake.
- Boundaries:
  - X=0 at load: the first rising edge goes LOAD->DONE.
  - XR==YR: SUB (I1=1); the next edge sees I0=0 and goes to DONE.
  - Y=0, X>0: the FSM remains in SUB indefinitely (I0=1, I1=1 persist). No timeout is required; software/bench must avoid this case.
  - Reset asserted mid-computation: the state returns to LOAD at once and decode follows combinationally. Computation restarts one cycle after rst is released.
- Undefined flag inputs (X/Z) must not be relied on. The bench drives known values.

Test Plan:
- Reset: rst=0 with clk running -> {D1,D0}=00, SelectXY=LoadXR=LoadYR=1, Subtract=Swap=0. Release rst; the state changes only on a rising edge.
- GCD(12,8) flag sequence from the datapath model:
  - Expected states: 00, 01 (XR=4), 10 (swap 8/4), 01 (XR=4), 01 (XR=0), 11.
  - DONE holds with all strobes 0; the datapath's Z=4.
- Priority: from SUB drive I0=0, I1=1 -> next state DONE (11), not SUB.
- Swap path: from LOAD drive I0=1, I1=0 -> SWAP (10) with Swap=1, Subtract=0. Then I0=1, I1=1 -> SUB (01).
- DONE stickiness: in 11, toggle I0/I1 through all four combinations for 5 cycles -> the state stays 11 and all strobes stay 0.
- Async reset mid-run: in SWAP, assert rst low between clock edges -> D1/D0 go to 00 before the next rising edge. After release, the sequence restarts from LOAD.
